// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the program loader.
// State encoding, frame markers and memory geometry.
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        DATA,
        CHK,
        FILL,
        DONE,
        ERR
    } state_t;

    localparam int         DEPTH       = 32;
    localparam int         ADDR_W      = 5;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] HLT         = 8'h00;
    localparam int         TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/posedge_detection.sv
// Registered rising-edge detector.
// pulse is high for one cycle, the cycle after sig rises.
module posedge_detection (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    // Remember last input and register the rise
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sig_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sig_q <= sig;
            pulse <= sig & ~sig_q;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Frame parser that downloads a program into instruction memory.
// Holds the CPU until sync/len/payload/checksum all check out.
module program_loader
    import cpu_loader_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_fe,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [5:0]        byte_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state, state_n;

    logic              start;
    logic [5:0]        len, len_n;
    logic [7:0]        chk, chk_n;
    logic [5:0]        fill, fill_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic [5:0]        cnt_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              tmo_run;
    logic              tmo_hit;

    posedge_detection u_load_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (Load),
        .pulse (start)
    );

    // Status follows the state: only DONE releases the CPU
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);

    // Inter-byte watchdog is live only while a frame is in flight
    assign tmo_run = (state == LEN) || (state == DATA) || (state == CHK);
    assign tmo_hit = tmo_run && !rx_valid && (tmo == TW'(TIMEOUT - 1));

    // Next-state, datapath and write-port decode
    always_comb begin
        state_n = state;
        len_n   = len;
        chk_n   = chk;
        fill_n  = fill;
        tmo_n   = tmo;
        cnt_n   = byte_count;
        we_n    = 1'b0;
        addr_n  = im_addr;
        wdata_n = im_wdata;

        if (tmo_run) begin
            tmo_n = rx_valid ? '0 : tmo + TW'(1);
        end

        if (start) begin
            state_n = SYNC;
            cnt_n   = '0;
            tmo_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                SYNC: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_n = LEN;
                        tmo_n   = '0;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        if (rx_fe) begin
                            state_n = ERR;
                        end else if (rx_data == 8'd0 ||
                                     rx_data > 8'(DEPTH)) begin
                            state_n = ERR;
                        end else begin
                            len_n   = rx_data[5:0];
                            chk_n   = rx_data;
                            state_n = DATA;
                        end
                    end else if (tmo_hit) begin
                        state_n = ERR;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        if (rx_fe) begin
                            state_n = ERR;
                        end else begin
                            we_n    = 1'b1;
                            addr_n  = byte_count[ADDR_W-1:0];
                            wdata_n = rx_data;
                            cnt_n   = byte_count + 6'd1;
                            chk_n   = chk ^ rx_data;
                            if (cnt_n == len) begin
                                state_n = CHK;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_n = ERR;
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        if (rx_fe || rx_data != chk) begin
                            state_n = ERR;
                        end else if (len == 6'(DEPTH)) begin
                            state_n = DONE;
                        end else begin
                            state_n = FILL;
                            fill_n  = len;
                        end
                    end else if (tmo_hit) begin
                        state_n = ERR;
                    end
                end
                FILL: begin
                    we_n    = 1'b1;
                    addr_n  = fill[ADDR_W-1:0];
                    wdata_n = HLT;
                    fill_n  = fill + 6'd1;
                    if (fill == 6'(DEPTH - 1)) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                end
                ERR: begin
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            len        <= '0;
            chk        <= '0;
            fill       <= '0;
            tmo        <= '0;
            byte_count <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            chk        <= chk_n;
            fill       <= fill_n;
            tmo        <= tmo_n;
            byte_count <= cnt_n;
            im_we      <= we_n;
            im_addr    <= addr_n;
            im_wdata   <= wdata_n;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised frame-level bench for program_loader.
// Expected writes and status come from a frame parser model.
module tb_program_loader;
    import cpu_loader_pkg::*;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
        logic [5:0] bc;
        logic       chain;
    } wr_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_fe = 1'b0;
    logic       im_we;
    logic [4:0] im_addr;
    logic [7:0] im_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [5:0] byte_count;

    program_loader #(.TIMEOUT(100)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_fe      (rx_fe),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    always #5 Clk = ~Clk;

    int         errors = 0;
    int         checks = 0;
    int         nwr = 0;
    bit         prev_we = 1'b0;
    wr_t        expq[$];
    logic [7:0] mem_exp[32];
    logic [7:0] mem_dut[32];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model's expected write stream
    task automatic compare();
        wr_t e;
        if (Reset) begin
            prev_we = 1'b0;
            return;
        end
        chk("hold_vs_done", {31'd0, cpu_hold}, {31'd0, ~load_done});
        if (im_we === 1'b1) begin
            nwr++;
            mem_dut[im_addr] = im_wdata;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h",
                         im_addr, im_wdata);
            end else begin
                e = expq.pop_front();
                chk("write", {13'd0, im_addr, im_wdata, byte_count},
                    {13'd0, e.addr, e.data, e.bc});
                if (e.chain) chk("fill_consecutive", {31'd0, prev_we}, 32'd1);
            end
        end
        prev_we = (im_we === 1'b1);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        compare();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fe);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_fe    = fe;
        tick();
        rx_valid = 1'b0;
        rx_fe    = 1'b0;
    endtask

    task automatic start_load();
        Load = 1'b1;
        tick();
        tick();
        Load = 1'b0;
        chk("start_err",  {31'd0, load_err},  32'd0);
        chk("start_done", {31'd0, load_done}, 32'd0);
        chk("start_bc",   {26'd0, byte_count}, 32'd0);
        nwr = 0;
    endtask

    // Frame parser: st 0=incomplete, 1=done, 2=error
    task automatic model_frame(input logic [7:0] b[$], input bit f[$],
                               output int st, output int bc);
        int i;
        int L;
        logic [7:0] ck;
        wr_t w;
        st = 0;
        bc = 0;
        i = 0;
        while (i < b.size() && b[i] != SYNC_BYTE) i++;
        if (i >= b.size()) return;
        i++;
        if (i >= b.size()) return;
        if (f[i] || b[i] == 8'd0 || b[i] > 8'd32) begin
            st = 2;
            return;
        end
        L  = int'(b[i]);
        ck = b[i];
        i++;
        for (int k = 0; k < L; k++) begin
            if (i >= b.size()) return;
            if (f[i]) begin
                st = 2;
                return;
            end
            w = '{addr: 5'(k), data: b[i], bc: 6'(k + 1), chain: 1'b0};
            expq.push_back(w);
            mem_exp[k] = b[i];
            ck = ck ^ b[i];
            bc = k + 1;
            i++;
        end
        if (i >= b.size()) return;
        if (f[i] || b[i] != ck) begin
            st = 2;
            return;
        end
        for (int a = L; a < 32; a++) begin
            w = '{addr: 5'(a), data: 8'h00, bc: 6'(L), chain: (a != L)};
            expq.push_back(w);
            mem_exp[a] = 8'h00;
        end
        st = 1;
    endtask

    task automatic check_mem(input string name);
        int bad = -1;
        for (int a = 0; a < 32; a++)
            if (mem_dut[a] !== mem_exp[a] && bad < 0) bad = a;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s mem[%0d] act=%h exp=%h",
                     name, bad, mem_dut[bad], mem_exp[bad]);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] b[$],
                             input bit f[$], input int maxgap);
        int st;
        int bc;
        start_load();
        model_frame(b, f, st, bc);
        foreach (b[i]) begin
            send_byte(b[i], f[i]);
            repeat ($urandom_range(0, maxgap)) tick();
        end
        repeat (40) tick();
        if (st == 1) begin
            chk({name, "_done"}, {31'd0, load_done}, 32'd1);
            chk({name, "_hold"}, {31'd0, cpu_hold},  32'd0);
            chk({name, "_err"},  {31'd0, load_err},  32'd0);
        end else if (st == 2) begin
            chk({name, "_done"}, {31'd0, load_done}, 32'd0);
            chk({name, "_hold"}, {31'd0, cpu_hold},  32'd1);
            chk({name, "_err"},  {31'd0, load_err},  32'd1);
        end
        chk({name, "_bc"}, {26'd0, byte_count}, 32'(bc));
        chk({name, "_drain"}, 32'(expq.size()), 32'd0);
        expq.delete();
        check_mem(name);
    endtask

    task automatic gen_frame(output logic [7:0] b[$], output bit f[$]);
        logic [7:0] j;
        logic [7:0] L;
        logic [7:0] ck;
        b = {};
        f = {};
        repeat ($urandom_range(0, 2)) begin
            j = 8'($urandom_range(0, 255));
            if (j == SYNC_BYTE) j = 8'h5A;
            b.push_back(j);
            f.push_back(1'b0);
        end
        b.push_back(SYNC_BYTE);
        f.push_back(1'b0);
        if ($urandom_range(0, 9) == 0)
            L = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255));
        else
            L = 8'($urandom_range(1, 32));
        b.push_back(L);
        f.push_back(1'b0);
        ck = L;
        if (L >= 8'd1 && L <= 8'd32) begin
            for (int k = 0; k < int'(L); k++) begin
                j = 8'($urandom_range(0, 255));
                ck = ck ^ j;
                b.push_back(j);
                f.push_back(1'b0);
            end
            if ($urandom_range(0, 7) == 0) ck = ck ^ 8'h01;
            b.push_back(ck);
            f.push_back(1'b0);
        end
        if ($urandom_range(0, 7) == 0)
            f[$urandom_range(b.size() - int'(L) - 2, b.size() - 1)] = 1'b1;
    endtask

    initial begin
        logic [7:0] b[$];
        bit         f[$];
        logic [7:0] x;
        wr_t        w;

        for (int a = 0; a < 32; a++) begin
            mem_exp[a] = 8'hEE;
            mem_dut[a] = 8'hEE;
        end

        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_we",    {31'd0, im_we},     32'd0);
        chk("rst_addr",  {27'd0, im_addr},   32'd0);
        chk("rst_wdata", {24'd0, im_wdata},  32'd0);
        chk("rst_hold",  {31'd0, cpu_hold},  32'd1);
        chk("rst_done",  {31'd0, load_done}, 32'd0);
        chk("rst_err",   {31'd0, load_err},  32'd0);
        chk("rst_bc",    {26'd0, byte_count}, 32'd0);
        Reset = 1'b0;
        tick();

        b = {8'hA5, 8'h02, 8'h21, 8'h7F, 8'h5C};
        f = {0, 0, 0, 0, 0};
        run_frame("good2", b, f, 2);
        chk("good2_nwr", 32'(nwr), 32'd32);
        chk("good2_bc_lit", {26'd0, byte_count}, 32'd2);
        chk("good2_done_lit", {31'd0, load_done}, 32'd1);
        chk("good2_m1", {24'd0, mem_dut[1]}, 32'h7F);

        b = {8'h13, 8'hFF, 8'hA5, 8'h01, 8'h40, 8'h41};
        f = {0, 0, 0, 0, 0, 0};
        run_frame("junk", b, f, 1);
        chk("junk_m0", {24'd0, mem_dut[0]}, 32'h40);
        chk("junk_nwr", 32'(nwr), 32'd32);

        b = {8'hA5, 8'h02, 8'h21, 8'h7F, 8'h00};
        f = {0, 0, 0, 0, 0};
        run_frame("badck", b, f, 1);
        chk("badck_nwr", 32'(nwr), 32'd2);
        chk("badck_err_lit", {31'd0, load_err}, 32'd1);

        b = {8'hA5, 8'h00};
        f = {0, 0};
        run_frame("len0", b, f, 0);
        chk("len0_nwr", 32'(nwr), 32'd0);

        b = {8'hA5, 8'h21};
        f = {0, 0};
        run_frame("len33", b, f, 0);
        chk("len33_nwr", 32'(nwr), 32'd0);

        b = {8'hA5, 8'h20};
        f = {0, 0};
        x = 8'h20;
        for (int k = 0; k < 32; k++) begin
            b.push_back(8'($urandom_range(0, 255)));
            f.push_back(1'b0);
            x = x ^ b[$];
        end
        b.push_back(x);
        f.push_back(1'b0);
        run_frame("len32", b, f, 1);
        chk("len32_nwr", 32'(nwr), 32'd32);
        chk("len32_bc_lit", {26'd0, byte_count}, 32'd32);

        b = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        f = {0, 0, 0, 1, 0, 0};
        run_frame("fe", b, f, 1);
        chk("fe_nwr", 32'(nwr), 32'd1);
        chk("fe_err_lit", {31'd0, load_err}, 32'd1);
        b = {8'hA5, 8'h01, 8'h99, 8'h98};
        f = {0, 0, 0, 0};
        run_frame("recover", b, f, 1);
        chk("recover_err_lit", {31'd0, load_err}, 32'd0);

        start_load();
        w = '{addr: 5'd0, data: 8'h11, bc: 6'd1, chain: 1'b0};
        expq.push_back(w);
        mem_exp[0] = 8'h11;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 99) chk("tmo_99", {31'd0, load_err}, 32'd0);
            if (k == 100) chk("tmo_100", {31'd0, load_err}, 32'd1);
        end
        chk("tmo_bc", {26'd0, byte_count}, 32'd1);
        chk("tmo_drain", 32'(expq.size()), 32'd0);
        expq.delete();

        start_load();
        w = '{addr: 5'd0, data: 8'hAA, bc: 6'd1, chain: 1'b0};
        expq.push_back(w);
        w = '{addr: 5'd1, data: 8'hBB, bc: 6'd2, chain: 1'b0};
        expq.push_back(w);
        mem_exp[0] = 8'hAA;
        mem_exp[1] = 8'hBB;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #3;
        Reset = 1'b1;
        #1;
        chk("mrst_we",    {31'd0, im_we},     32'd0);
        chk("mrst_addr",  {27'd0, im_addr},   32'd0);
        chk("mrst_wdata", {24'd0, im_wdata},  32'd0);
        chk("mrst_hold",  {31'd0, cpu_hold},  32'd1);
        chk("mrst_done",  {31'd0, load_done}, 32'd0);
        chk("mrst_err",   {31'd0, load_err},  32'd0);
        chk("mrst_bc",    {26'd0, byte_count}, 32'd0);
        chk("mrst_drain", 32'(expq.size()), 32'd0);
        expq.delete();
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check_mem("mrst_mem");

        for (int n = 0; n < 40; n++) begin
            gen_frame(b, f);
            run_frame("rand", b, f, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
